clk_div_prog_duty: RTL and testbench
====================================

// Module: clk_div_prog_duty
// PURPOSE
//  Runtime-programmable integer clock divider with half-cycle duty resolution.
//  Next generation of the fixed divide-by-2 / 25%-duty divider.
//  Generates out = clk / div, high for 'high' half-cycles of clk.
//  Used as a local derived-clock / strobe source; config changes apply glitch-free at period boundaries.
// PARAMETERS
//  CNT_W     8  width of divide-ratio counter; div range 2..2^CNT_W-1
//  DEF_DIV   2  active divide ratio after reset
//  DEF_HIGH  1  active high time after reset, in clk half-cycles (2/1 = div-by-2, 25% duty)
// PORTS
//  clk          in   1        single clock; posedge main domain, negedge used only for duty trim
//  reset        in   1        asynchronous, active-low (0 = reset); async assert, release sync to clk
//  enable       in   1        1 = run divider; 0 = hold idle
//  cfg_load     in   1        1-cycle pulse: capture div_in/high_in
//  div_in       in   CNT_W    requested divide ratio (clk cycles per out period)
//  high_in      in   CNT_W+1  requested high time in clk half-cycles
//  out          out  1        divided output
//  period_start out  1        1-cycle pulse (posedge domain) in first clk cycle of each out period
//  cfg_pending  out  1        1 = accepted config waiting for next period boundary
//  cfg_err      out  1        1-cycle pulse: last cfg_load rejected
// BEHAVIOUR
//  - Reset: out=0, period_start=0, cfg_pending=0, cfg_err=0, cnt=0, active div/high = DEF_DIV/DEF_HIGH, shadow cleared.
//  - Counter cnt: posedge, 0..div-1, wraps to 0; cnt==0 marks period start; period_start=(cnt==0)&enable, registered-aligned with out rise.
//  - Duty: H=ceil(high/2); out_p (posedge reg) = 1 while cnt<H.
//    If high odd: tail flop (negedge) sets in 2nd half of cycle cnt==H-1, clears next negedge.
//    out = out_p & ~tail. Net: out high exactly 'high' half-cycles from period start.
//  - Valid config: 2<=div_in, 1<=high_in<=2*div_in-1. Otherwise cfg_err pulses next cycle, active and shadow unchanged.
//  - Valid cfg_load: stored in shadow, cfg_pending=1. At next wrap (cnt==div-1 -> 0) shadow becomes active; cfg_pending clears that cycle.
//  - cfg_load when idle (enable=0): applies immediately, cfg_pending stays 0.
//  - Second valid cfg_load while pending: overwrites shadow (last wins).
//  - cfg_load in the same cycle as the wrap: the new value applies at the following wrap (earliest = next period).
//  - enable 1->0: out=0, tail=0, cnt=0 next posedge, including mid high phase (truncation allowed).
//    enable 0->1: first period starts on the next posedge (cnt=0, out rises).
//  - Reset mid-operation: immediate return to reset state, including any pending config.
//  - Widths: compare high against {div,1'b0}-1 at CNT_W+1 bits, no truncation.
// STRUCTURE
//  - Package clk_div_pkg: CNT_W default, cfg_t struct {div, high}, function cfg_valid(div, high).
//  - Sub-module clk_div_tail: negedge trim flop plus output AND gate, with async active-low reset.
//    Isolates the only negedge logic for timing/CDC review.
//  - Top level: counter, active/shadow cfg regs, validation, period_start.
// TESTING (clk 10 ns)
//  1. Reset, enable=1, defaults -> out period 20 ns, high 5 ns; period_start every 2 clk.
//  2. Load div=5, high=5 -> after boundary: period 50 ns, high 25 ns (odd 50% duty via tail).
//  3. Load div=4, high=6 mid-period -> cfg_pending=1 until wrap; old shape finishes; then 40 ns period, 30 ns high.
//  4. Load div=1 or div=3/high=6 -> cfg_err 1-cycle pulse; waveform unchanged; cfg_pending=0.
//  5. Drop enable during high phase -> out=0 next edge; re-enable -> out rises next posedge, full period.
//  6. Assert reset mid-period with pending cfg -> all outputs 0; after release, DEF_DIV/DEF_HIGH waveform.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : clk_div_pkg
//  Brief    : Shared width, configuration record and validation helper for
//             the programmable-duty clock divider.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Default counter width; also sizes the configuration record.
  localparam int c_cnt_w = 8;

  // One divider configuration: ratio in clk cycles, high time in half-cycles.
  typedef struct packed {
    logic [c_cnt_w-1:0] div;
    logic [c_cnt_w:0]   high;
  } cfg_t;

  // Legal when div >= 2 and 1 <= high <= 2*div-1. The limit is formed at
  // full CNT_W+1 width so a large div never truncates.
  function automatic logic cfg_valid(input logic [c_cnt_w-1:0] div,
                                     input logic [c_cnt_w:0]   high);
    logic [c_cnt_w:0] lim;
    lim = {div, 1'b0} - {{c_cnt_w{1'b0}}, 1'b1};
    return (div >= c_cnt_w'(2)) && (high != '0) && (high <= lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_tail.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : clk_div_tail
//  Brief    : Half-cycle trim for odd high times. The only falling-edge logic
//             in the divider lives here, together with the output gate.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_tail (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trim,      // cycle in which the last high half must be removed
  input  logic i_out_fall,  // out_p falls at the coming rising edge
  input  logic i_out_p,     // rising-edge high phase
  output logic o_out
);

  logic r_tail_n;
  logic r_tail_p;

  // Falling edge: flip once to open the mask for the second half of the trim cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)      r_tail_n <= 1'b0;
    else if (i_trim) r_tail_n <= ~r_tail_n;
  end

  // Rising edge: close the mask, but not on the edge where out_p itself falls,
  // so the output never sees out_p=1 with the mask already gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_tail_p <= 1'b0;
    else if (!i_out_fall) r_tail_p <= r_tail_n;
  end

  // Mask is active only between the falling-edge flip and the realigning rising edge.
  assign o_out = i_out_p & ~(r_tail_n ^ r_tail_p);

endmodule
`default_nettype wire

// File: rtl/clk_div_prog_duty.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : clk_div_prog_duty
//  Brief    : Runtime-programmable integer clock divider, duty set in clk
//             half-cycles; new settings take effect at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog_duty
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = c_cnt_w,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W:0]   high_in,
  output logic             out,
  output logic             period_start,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam cfg_t c_cfg_def = '{div: c_cnt_w'(DEF_DIV), high: (c_cnt_w+1)'(DEF_HIGH)};

  cfg_t             r_act;
  cfg_t             r_shd;
  cfg_t             w_cfg_in;
  cfg_t             w_cfg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_h_act;
  logic [CNT_W-1:0] w_h_nxt;
  logic             r_run;
  logic             r_out_p;
  logic             r_ps;
  logic             r_pend;
  logic             r_err;
  logic             w_valid;
  logic             w_load_ok;
  logic             w_wrap;
  logic             w_out_p_nxt;
  logic             w_out_fall;
  logic             w_trim;

  // Next count, next effective config and next high phase, all for the coming rising edge.
  always_comb begin
    w_cfg_in  = '{div: div_in, high: high_in};
    w_valid   = cfg_valid(div_in, high_in);
    w_load_ok = cfg_load & w_valid;
    w_wrap    = r_run & (r_cnt == r_act.div - CNT_W'(1));

    w_cfg_nxt = r_act;
    if (w_wrap && r_pend) w_cfg_nxt = r_shd;

    if (!enable || !r_run || w_wrap) w_cnt_nxt = '0;
    else                             w_cnt_nxt = r_cnt + CNT_W'(1);

    // ceil(high/2) full cycles carry the high phase; fits CNT_W since high <= 2*div-1.
    w_h_nxt     = w_cfg_nxt.high[CNT_W:1] + CNT_W'(w_cfg_nxt.high[0]);
    w_h_act     = r_act.high[CNT_W:1] + CNT_W'(r_act.high[0]);
    w_out_p_nxt = enable & (w_cnt_nxt < w_h_nxt);
    w_out_fall  = r_out_p & ~w_out_p_nxt;
    w_trim      = r_out_p & r_act.high[0] & (r_cnt == w_h_act - CNT_W'(1));
  end

  // Counter, run flag and rising-edge outputs; period_start lines up with the out rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_out_p <= 1'b0;
      r_ps    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_run   <= enable;
      r_cnt   <= w_cnt_nxt;
      r_out_p <= w_out_p_nxt;
      r_ps    <= enable & (w_cnt_nxt == '0);
      r_err   <= cfg_load & ~w_valid;
    end
  end

  // Active/shadow configuration. While idle there is no period in flight, so
  // loads (and anything still pending) become active straight away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act  <= c_cfg_def;
      r_shd  <= '0;
      r_pend <= 1'b0;
    end else if (!enable) begin
      r_pend <= 1'b0;
      if (w_load_ok)   r_act <= w_cfg_in;
      else if (r_pend) r_act <= r_shd;
    end else begin
      r_act <= w_cfg_nxt;
      if (w_load_ok) begin
        r_shd  <= w_cfg_in;
        r_pend <= 1'b1;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  clk_div_tail u_tail (
    .clk        (clk),
    .rst_n      (reset),
    .i_trim     (w_trim),
    .i_out_fall (w_out_fall),
    .i_out_p    (r_out_p),
    .o_out      (out)
  );

  assign period_start = r_ps;
  assign cfg_pending  = r_pend;
  assign cfg_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog_duty.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_clk_div_prog_duty
//  Brief    : Directed self-checking bench for clk_div_prog_duty.
//             Waveforms are sampled per half-cycle, first half then second.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog_duty;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_load;
  logic [7:0] div_in;
  logic [8:0] high_in;
  logic       out;
  logic       period_start;
  logic       cfg_pending;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_prog_duty #(.CNT_W(8), .DEF_DIV(2), .DEF_HIGH(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_load     (cfg_load),
    .div_in       (div_in),
    .high_in      (high_in),
    .out          (out),
    .period_start (period_start),
    .cfg_pending  (cfg_pending),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  // Advance to 2 ns after the next rising edge.
  task automatic step();
    @(posedge clk); #2;
  endtask

  // Record n cycles starting with the current one: two out samples per cycle
  // (first half, second half) and one period_start sample per cycle.
  task automatic capture(input int n, output logic [63:0] wave, output logic [31:0] pss);
    wave = '0;
    pss  = '0;
    for (int i = 0; i < n; i++) begin
      wave = {wave[62:0], out};
      pss  = {pss[30:0], period_start};
      @(negedge clk); #2;
      wave = {wave[62:0], out};
      @(posedge clk); #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; cfg_load = 1'b0; div_in = '0; high_in = '0;
    repeat (3) step();
    n_checks++; if (out !== 1'b0)          begin n_fail++; $display("FAIL reset_out: got %b want 0", out); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b want 0", period_start); end
    n_checks++; if (cfg_pending !== 1'b0)  begin n_fail++; $display("FAIL reset_pending: got %b want 0", cfg_pending); end
    n_checks++; if (cfg_err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    reset = 1'b1;
    step();
  endtask

  // Defaults: div 2, high 1 half-cycle.
  task automatic test_default();
    logic [63:0] w; logic [31:0] p;
    enable = 1'b1;
    step();
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL default_first_ps: got %b want 1", period_start); end
    n_checks++; if (out !== 1'b1)          begin n_fail++; $display("FAIL default_first_out: got %b want 1", out); end
    capture(6, w, p);
    n_checks++; if (w !== 64'b100010001000) begin n_fail++; $display("FAIL default_wave: got %b want %b", w, 64'b100010001000); end
    n_checks++; if (p !== 32'b101010)       begin n_fail++; $display("FAIL default_ps: got %b want %b", p, 32'b101010); end
  endtask

  // Starts at cnt 0 of a default period; loads div 5 / high 5.
  task automatic test_odd_duty();
    logic [63:0] w; logic [31:0] p;
    cfg_load = 1'b1; div_in = 8'd5; high_in = 9'd5;
    step();
    cfg_load = 1'b0;
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL odd_pending_set: got %b want 1", cfg_pending); end
    n_checks++; if (out !== 1'b0)         begin n_fail++; $display("FAIL odd_old_shape: got %b want 0", out); end
    step();
    n_checks++; if (cfg_pending !== 1'b0)  begin n_fail++; $display("FAIL odd_pending_clr: got %b want 0", cfg_pending); end
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL odd_ps_at_wrap: got %b want 1", period_start); end
    capture(10, w, p);
    n_checks++; if (w !== 64'b11111000001111100000) begin n_fail++; $display("FAIL odd_wave: got %b want %b", w, 64'b11111000001111100000); end
    n_checks++; if (p !== 32'b1000010000)           begin n_fail++; $display("FAIL odd_ps: got %b want %b", p, 32'b1000010000); end
  endtask

  // Starts at cnt 0 of div 5. Two loads mid-period: the second one must win.
  task automatic test_pending();
    logic [63:0] w; logic [31:0] p;
    step();
    cfg_load = 1'b1; div_in = 8'd7; high_in = 9'd3;
    step();
    div_in = 8'd4; high_in = 9'd6;
    step();
    cfg_load = 1'b0;
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL pend_held: got %b want 1", cfg_pending); end
    capture(2, w, p);
    n_checks++; if (w !== 64'b0000) begin n_fail++; $display("FAIL pend_old_tail: got %b want %b", w, 64'b0000); end
    n_checks++; if (cfg_pending !== 1'b0)  begin n_fail++; $display("FAIL pend_clr: got %b want 0", cfg_pending); end
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL pend_ps: got %b want 1", period_start); end
    capture(8, w, p);
    n_checks++; if (w !== 64'b1111110011111100) begin n_fail++; $display("FAIL pend_wave: got %b want %b", w, 64'b1111110011111100); end
    n_checks++; if (p !== 32'b10001000)         begin n_fail++; $display("FAIL pend_ps_seq: got %b want %b", p, 32'b10001000); end
  endtask

  // Starts at cnt 0 of div 4. Load on the wrap cycle: applies one period later.
  // New setting div 2 / high 3 is the maximum high time for its ratio.
  task automatic test_wrap_load();
    logic [63:0] w; logic [31:0] p;
    repeat (3) step();
    cfg_load = 1'b1; div_in = 8'd2; high_in = 9'd3;
    step();
    cfg_load = 1'b0;
    n_checks++; if (cfg_pending !== 1'b1)  begin n_fail++; $display("FAIL wrap_pending: got %b want 1", cfg_pending); end
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL wrap_ps: got %b want 1", period_start); end
    capture(4, w, p);
    n_checks++; if (w !== 64'b11111100) begin n_fail++; $display("FAIL wrap_old_period: got %b want %b", w, 64'b11111100); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL wrap_pending_clr: got %b want 0", cfg_pending); end
    capture(4, w, p);
    n_checks++; if (w !== 64'b11101110) begin n_fail++; $display("FAIL wrap_max_high: got %b want %b", w, 64'b11101110); end
    n_checks++; if (p !== 32'b1010)     begin n_fail++; $display("FAIL wrap_ps_seq: got %b want %b", p, 32'b1010); end
  endtask

  // Starts at cnt 0 of div 2 / high 3. Three rejected loads back to back.
  task automatic test_cfg_err();
    logic [63:0] w; logic [31:0] p;
    cfg_load = 1'b1; div_in = 8'd1; high_in = 9'd1;
    step();
    n_checks++; if (cfg_err !== 1'b1)     begin n_fail++; $display("FAIL err_div1: got %b want 1", cfg_err); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL err_div1_pending: got %b want 0", cfg_pending); end
    div_in = 8'd3; high_in = 9'd6;
    step();
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_high_over: got %b want 1", cfg_err); end
    div_in = 8'd4; high_in = 9'd0;
    step();
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_high_zero: got %b want 1", cfg_err); end
    cfg_load = 1'b0;
    step();
    n_checks++; if (cfg_err !== 1'b0)     begin n_fail++; $display("FAIL err_pulse_end: got %b want 0", cfg_err); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL err_no_pending: got %b want 0", cfg_pending); end
    capture(4, w, p);
    n_checks++; if (w !== 64'b11101110) begin n_fail++; $display("FAIL err_wave_kept: got %b want %b", w, 64'b11101110); end
  endtask

  // Starts at cnt 0 (high phase) of div 2 / high 3. Drop enable, load while idle, re-enable.
  task automatic test_enable_drop();
    logic [63:0] w; logic [31:0] p;
    enable = 1'b0;
    step();
    n_checks++; if (out !== 1'b0)          begin n_fail++; $display("FAIL dis_out: got %b want 0", out); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL dis_ps: got %b want 0", period_start); end
    capture(3, w, p);
    n_checks++; if (w !== 64'b0 || p !== 32'b0) begin n_fail++; $display("FAIL dis_idle: got %b/%b want 0/0", w, p); end
    cfg_load = 1'b1; div_in = 8'd3; high_in = 9'd3;
    step();
    cfg_load = 1'b0;
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL idle_load_pending: got %b want 0", cfg_pending); end
    enable = 1'b1;
    step();
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL reen_ps: got %b want 1", period_start); end
    n_checks++; if (out !== 1'b1)          begin n_fail++; $display("FAIL reen_out: got %b want 1", out); end
    capture(6, w, p);
    n_checks++; if (w !== 64'b111000111000) begin n_fail++; $display("FAIL reen_wave: got %b want %b", w, 64'b111000111000); end
    n_checks++; if (p !== 32'b100100)       begin n_fail++; $display("FAIL reen_ps_seq: got %b want %b", p, 32'b100100); end
  endtask

  // Starts at cnt 0 of div 3 / high 3. Reset with a pending config in the high phase.
  task automatic test_reset_mid();
    logic [63:0] w; logic [31:0] p;
    cfg_load = 1'b1; div_in = 8'd6; high_in = 9'd7;
    step();
    cfg_load = 1'b0;
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", cfg_pending); end
    n_checks++; if (out !== 1'b1)         begin n_fail++; $display("FAIL rmid_out_before: got %b want 1", out); end
    reset = 1'b0;
    #1;
    n_checks++; if (out !== 1'b0)          begin n_fail++; $display("FAIL rmid_out: got %b want 0", out); end
    n_checks++; if (cfg_pending !== 1'b0)  begin n_fail++; $display("FAIL rmid_pending_clr: got %b want 0", cfg_pending); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rmid_ps: got %b want 0", period_start); end
    repeat (2) step();
    reset = 1'b1;
    step();
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_ps: got %b want 1", period_start); end
    capture(6, w, p);
    n_checks++; if (w !== 64'b100010001000) begin n_fail++; $display("FAIL rmid_default_wave: got %b want %b", w, 64'b100010001000); end
    n_checks++; if (cfg_pending !== 1'b0)   begin n_fail++; $display("FAIL rmid_no_pending: got %b want 0", cfg_pending); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_odd_duty();
    test_pending();
    test_wrap_load();
    test_cfg_err();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
